mux_n1_stream: RTL and testbench
================================

// Module: mux_n1_stream
// PURPOSE
//  Parametrised N:1 streaming multiplexer; successor to the 2:1 combinational mux.
//  Selects one of CH_NUM valid/ready input channels of DATA_W bits into one
//  registered output stage with full valid/ready back-pressure.
//  Sits between multiple producers and a single consumer (UART tx, FIFO, LED driver).
// PARAMETERS
//  DATA_W  8  width of each channel's data word
//  CH_NUM  4  number of input channels (>=2)
//  SEL_W   $clog2(CH_NUM), localparam, width of select/index signals
// PORTS
//  sys_clk    in   1              system clock, all logic on rising edge
//  sys_rst_n  in   1              asynchronous active-low reset
//  in_data    in   CH_NUM*DATA_W  channel i occupies [i*DATA_W +: DATA_W]
//  in_valid   in   CH_NUM         per-channel data valid
//  in_ready   out  CH_NUM         per-channel ready (combinational)
//  sel        in   SEL_W          requested channel (manual mode)
//  out_data   out  DATA_W         registered output data
//  out_valid  out  1              registered output valid
//  out_ready  in   1              consumer ready
//  cur_sel    out  SEL_W          channel currently connected (registered)
// BEHAVIOUR
//  - Reset (async, sys_rst_n=0): out_data=0, out_valid=0, cur_sel=0; in_ready=0.
//  - slot_free = !out_valid || out_ready.
//  - in_ready[i] = sys_rst_n && slot_free && (i==cur_sel); all other bits 0.
//  - Accept: in_valid[cur_sel] && in_ready[cur_sel] -> next edge out_data<=channel
//    data, out_valid<=1. Latency 1 clock, throughput 1 beat/clock.
//  - No accept but out_valid && out_ready: out_valid<=0, out_data holds.
//  - out_valid && !out_ready: out_data/out_valid held stable; no input accepted.
//  - Select update (manual): when slot_free, cur_sel<=sel at the edge; a beat
//    accepted this cycle comes from the old cur_sel. While stalled, cur_sel holds.
//  - sel >= CH_NUM (non-power-of-2 CH_NUM): ignored, cur_sel holds.
//  - Non-selected channels never receive ready; their data is never lost.
//  - Reset mid-transfer: pending output beat discarded, out_valid drops immediately.
// CONFIGURATION
//  MUX_N1_AUTO_RR_EN defined: sel port ignored; round-robin arbitration.
//   After each accepted beat cur_sel moves to the next channel (cur_sel+1,
//   wrapping CH_NUM-1->0) that has in_valid=1, searching in order; none -> holds.
//   With no beat accepted and in_valid[cur_sel]=0 while slot_free, cur_sel
//   moves to the next requesting channel the same way (no idle starvation).
//  Undefined: manual select via sel as above; no arbitration logic built.
// TESTING
//  1 Reset: assert sys_rst_n=0 mid-beat -> out_valid=0, out_data=0, cur_sel=0 at once.
//  2 Manual select, out_ready=1: sel=2, ch2 sends 8'hA5,8'h5A back-to-back ->
//    out_data A5 then 5A on consecutive clocks, out_valid=1, in_ready=4'b0100.
//  3 Back-pressure: out_ready=0 with out_data=8'h3C held; ch2 valid 8'h77 ->
//    in_ready=0, out_data stays 3C; out_ready=1 -> next clock out_data=77.
//  4 Select during stall: out_ready=0, sel 1->3 -> cur_sel stays 1 until slot
//    frees, then cur_sel=3; no beat from ch1 or ch3 lost or duplicated.
//  5 Invalid sel (CH_NUM=3): sel=3 -> cur_sel unchanged, no channel ready changes.
//  6 AUTO_RR_EN: all 4 channels valid continuously (data=8'h10+ch) -> out_data
//    10,11,12,13,10... one per clock; only ch0,ch2 valid -> 10,12,10,12.

Source files
------------

// File: rtl/mux_n1_stream_if.sv
// Stream bundle for mux_n1_stream: CH_NUM producer channels in, one consumer out.
// slave = the multiplexer's view, master = the environment driving it.
interface mux_n1_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_NUM = 4
);
  localparam int unsigned SEL_W = $clog2(CH_NUM);

  logic [CH_NUM*DATA_W-1:0] in_data;
  logic [CH_NUM-1:0]        in_valid;
  logic [CH_NUM-1:0]        in_ready;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_W-1:0]         cur_sel;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, cur_sel
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, cur_sel
  );
endinterface

// File: rtl/mux_n1_stream.sv
// N:1 valid/ready stream multiplexer with one registered output slot.
// Define MUX_N1_AUTO_RR_EN for round-robin channel selection instead of the sel port.
module mux_n1_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH_NUM = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  mux_n1_stream_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(CH_NUM);

  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic [SEL_W-1:0]  cur_sel_q;
  logic [SEL_W-1:0]  cur_sel_d;

  logic              slot_free;
  logic              accept;
  logic [CH_NUM-1:0] in_ready_w;
  logic [DATA_W-1:0] ch_word [CH_NUM];
  logic [DATA_W-1:0] ch_data;

  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      ch_word[i] = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign ch_data = ch_word[cur_sel_q];

  always_comb begin
    in_ready_w = '0;
    if (sys_rst_n && slot_free) begin
      in_ready_w[cur_sel_q] = 1'b1;
    end
  end

  assign accept = |(bus.in_valid & in_ready_w);

`ifdef MUX_N1_AUTO_RR_EN
  logic [SEL_W-1:0] rr_next;
  logic             rr_found;
  logic             unused_sel;

  assign unused_sel = ^bus.sel;

  // First requester after cur_sel in wrap-around order; cur_sel itself is never a candidate.
  always_comb begin
    rr_next  = cur_sel_q;
    rr_found = 1'b0;
    for (int unsigned k = 1; k < CH_NUM; k++) begin
      logic [SEL_W-1:0] cand;
      cand = SEL_W'((32'(cur_sel_q) + k) % CH_NUM);
      if (!rr_found && bus.in_valid[cand]) begin
        rr_found = 1'b1;
        rr_next  = cand;
      end
    end
  end

  always_comb begin
    cur_sel_d = cur_sel_q;
    if (accept || (slot_free && !bus.in_valid[cur_sel_q])) begin
      cur_sel_d = rr_next;
    end
  end
`else
  always_comb begin
    cur_sel_d = cur_sel_q;
    if (slot_free && (32'(bus.sel) < CH_NUM)) begin
      cur_sel_d = bus.sel;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cur_sel_q   <= '0;
    end else begin
      if (accept) begin
        out_data_q  <= ch_data;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      cur_sel_q <= cur_sel_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cur_sel   = cur_sel_q;
endmodule

// File: tb/tb_mux_n1_stream.sv
// Self-checking bench for mux_n1_stream: directed vectors plus a randomized
// scoreboard run; round-robin checks apply when MUX_N1_AUTO_RR_EN is defined.
module tb_mux_n1_stream;
  localparam int unsigned DW = 8;
  localparam int unsigned CN = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  mux_n1_stream_if #(.DATA_W(DW), .CH_NUM(CN)) bus4 ();
  mux_n1_stream_if #(.DATA_W(DW), .CH_NUM(3))  bus3 ();

  mux_n1_stream #(.DATA_W(DW), .CH_NUM(CN)) dut4 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus4.slave));
  mux_n1_stream #(.DATA_W(DW), .CH_NUM(3)) dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus3.slave));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic [1:0]  ec;
    logic [3:0]  er;
  } vec_t;

  vec_t tbl [15];

  // Scoreboard state: queue of beats accepted but not yet consumed.
  logic [7:0]  sb [$];
  logic [7:0]  last_acc;
  logic [1:0]  m_cur;
  logic [7:0]  gen [4][64];
  int unsigned head [4];
  int unsigned total [4];
  int unsigned n_sent, n_recv, n_gen;

  function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] v);
    logic [1:0] r;
    r = cur;
    for (int k = 3; k >= 1; k--) begin
      logic [1:0] c;
      c = cur + 2'(k);
      if (v[c]) r = c;
    end
    return r;
  endfunction

  task automatic do_reset;
    sys_rst_n = 1'b0;
    bus4.in_data = '0; bus4.in_valid = '0; bus4.sel = '0; bus4.out_ready = 1'b0;
    bus3.in_data = '0; bus3.in_valid = '0; bus3.sel = '0; bus3.out_ready = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_in_ready", 32'(bus4.in_ready), 32'h0);
    @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    sb.delete();
    last_acc = '0;
    m_cur = '0;
  endtask

  task automatic rand_cycle(input bit drain);
    logic [3:0] iv;
    logic       slot, acc, pop;
    logic [3:0] er;
    logic [7:0] ed;
    bus4.out_ready = drain ? 1'b1 : ($urandom % 4 != 0);
    bus4.sel = 2'($urandom % 4);
    if (drain) begin
      bus4.sel = m_cur;
      for (int c = 3; c >= 0; c--) if (head[c] < total[c]) bus4.sel = 2'(c);
    end
    for (int c = 0; c < 4; c++) begin
      iv[c] = (head[c] < total[c]) && (drain || ($urandom % 3 != 0));
      bus4.in_data[c*8 +: 8] = (head[c] < total[c]) ? gen[c][head[c]] : 8'($urandom);
    end
    bus4.in_valid = iv;
    @(negedge sys_clk);
    slot = (sb.size() == 0) || bus4.out_ready;
    er = slot ? (4'b0001 << m_cur) : 4'b0000;
    ed = (sb.size() != 0) ? sb[0] : last_acc;
    chk("rnd_valid", 32'(bus4.out_valid), 32'(sb.size() != 0));
    chk("rnd_data", 32'(bus4.out_data), 32'(ed));
    chk("rnd_cur", 32'(bus4.cur_sel), 32'(m_cur));
    chk("rnd_ready", 32'(bus4.in_ready), 32'(er));
    acc = iv[m_cur] && slot;
    pop = (sb.size() != 0) && bus4.out_ready;
    @(posedge sys_clk);
    if (pop) begin
      void'(sb.pop_front());
      n_recv++;
    end
    if (acc) begin
      last_acc = gen[m_cur][head[m_cur]];
      sb.push_back(last_acc);
      head[m_cur]++;
      n_sent++;
    end
`ifdef MUX_N1_AUTO_RR_EN
    if (acc || (slot && !iv[m_cur])) m_cur = rr_pick(m_cur, iv);
`else
    if (slot) m_cur = bus4.sel;
`endif
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{2'd2, 4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0001};
    tbl[1]  = '{2'd2, 4'b0100, 32'h00A50000, 1'b1, 1'b0, 8'h00, 2'd2, 4'b0100};
    tbl[2]  = '{2'd2, 4'b0100, 32'h005A0000, 1'b1, 1'b1, 8'hA5, 2'd2, 4'b0100};
    tbl[3]  = '{2'd2, 4'b0100, 32'h003C0000, 1'b1, 1'b1, 8'h5A, 2'd2, 4'b0100};
    tbl[4]  = '{2'd2, 4'b0100, 32'h00770000, 1'b0, 1'b1, 8'h3C, 2'd2, 4'b0000};
    tbl[5]  = '{2'd2, 4'b0100, 32'h00770000, 1'b0, 1'b1, 8'h3C, 2'd2, 4'b0000};
    tbl[6]  = '{2'd2, 4'b0100, 32'h00770000, 1'b1, 1'b1, 8'h3C, 2'd2, 4'b0100};
    tbl[7]  = '{2'd1, 4'b0000, 32'h00000000, 1'b1, 1'b1, 8'h77, 2'd2, 4'b0100};
    tbl[8]  = '{2'd1, 4'b0010, 32'h00001100, 1'b0, 1'b0, 8'h77, 2'd1, 4'b0010};
    tbl[9]  = '{2'd3, 4'b1010, 32'h33002200, 1'b0, 1'b1, 8'h11, 2'd1, 4'b0000};
    tbl[10] = '{2'd3, 4'b1010, 32'h33002200, 1'b0, 1'b1, 8'h11, 2'd1, 4'b0000};
    tbl[11] = '{2'd3, 4'b1010, 32'h33002200, 1'b1, 1'b1, 8'h11, 2'd1, 4'b0010};
    tbl[12] = '{2'd3, 4'b1000, 32'h33000000, 1'b1, 1'b1, 8'h22, 2'd3, 4'b1000};
    tbl[13] = '{2'd3, 4'b0000, 32'h00000000, 1'b1, 1'b1, 8'h33, 2'd3, 4'b1000};
    tbl[14] = '{2'd3, 4'b0000, 32'h00000000, 1'b1, 1'b0, 8'h33, 2'd3, 4'b1000};

    do_reset();
    chk("post_rst_valid", 32'(bus4.out_valid), 32'h0);
    chk("post_rst_data", 32'(bus4.out_data), 32'h0);
    chk("post_rst_cur", 32'(bus4.cur_sel), 32'h0);

    // Reset arriving while a beat is pending in the output slot.
    bus4.sel = 2'd2; bus4.in_data = 32'h00C30000; bus4.in_valid = 4'b0100; bus4.out_ready = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk("pre_rst_valid", 32'(bus4.out_valid), 32'h1);
    chk("pre_rst_data", 32'(bus4.out_data), 32'hC3);
    chk("pre_rst_cur", 32'(bus4.cur_sel), 32'h2);
    bus4.in_valid = '0; bus4.out_ready = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus4.out_valid), 32'h0);
    chk("midrst_data", 32'(bus4.out_data), 32'h0);
    chk("midrst_cur", 32'(bus4.cur_sel), 32'h0);
    chk("midrst_ready", 32'(bus4.in_ready), 32'h0);

    do_reset();
`ifndef MUX_N1_AUTO_RR_EN
    for (int i = 0; i < 15; i++) begin
      bus4.sel = tbl[i].sel;
      bus4.in_valid = tbl[i].iv;
      bus4.in_data = tbl[i].data;
      bus4.out_ready = tbl[i].ordy;
      @(negedge sys_clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus4.out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(bus4.out_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_cur", i), 32'(bus4.cur_sel), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_ready", i), 32'(bus4.in_ready), 32'(tbl[i].er));
      @(posedge sys_clk); #1;
    end

    // Out-of-range select on a 3-channel instance.
    do_reset();
    bus3.out_ready = 1'b1;
    bus3.sel = 2'd1;
    @(posedge sys_clk); #1;
    chk("ch3_sel1_cur", 32'(bus3.cur_sel), 32'h1);
    chk("ch3_sel1_ready", 32'(bus3.in_ready), 32'h2);
    bus3.sel = 2'd3;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("ch3_sel3_cur", 32'(bus3.cur_sel), 32'h1);
    chk("ch3_sel3_ready", 32'(bus3.in_ready), 32'h2);
    bus3.sel = 2'd2;
    @(posedge sys_clk); #1;
    chk("ch3_sel2_cur", 32'(bus3.cur_sel), 32'h2);
    chk("ch3_sel2_ready", 32'(bus3.in_ready), 32'h4);
`else
    bus4.in_valid = 4'b1111; bus4.in_data = 32'h13121110; bus4.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("rr_all%0d_valid", k), 32'(bus4.out_valid), 32'h1);
      chk($sformatf("rr_all%0d_data", k), 32'(bus4.out_data), 32'(8'h10 + 8'(k % 4)));
    end
    do_reset();
    bus4.in_valid = 4'b0101; bus4.in_data = 32'h13121110; bus4.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge sys_clk); #1;
      chk($sformatf("rr_02_%0d_valid", k), 32'(bus4.out_valid), 32'h1);
      chk($sformatf("rr_02_%0d_data", k), 32'(bus4.out_data), 32'(8'h10 + 8'(2 * (k % 2))));
    end
`endif

    // Randomized traffic against the scoreboard, then drain everything.
    do_reset();
    n_sent = 0; n_recv = 0; n_gen = 0;
    for (int c = 0; c < 4; c++) begin
      head[c] = 0;
      total[c] = 20 + ($urandom % 40);
      n_gen += total[c];
      for (int j = 0; j < 64; j++) gen[c][j] = 8'($urandom);
    end
    for (int t = 0; t < 300; t++) rand_cycle(1'b0);
    begin
      int budget;
      budget = 0;
      while (((head[0] < total[0]) || (head[1] < total[1]) || (head[2] < total[2]) ||
              (head[3] < total[3]) || (sb.size() != 0)) && (budget < 600)) begin
        rand_cycle(1'b1);
        budget++;
      end
      chk("drain_budget", 32'(budget < 600), 32'h1);
    end
    chk("beats_sent", n_sent, n_gen);
    chk("beats_recv", n_recv, n_gen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
